// File: rtl/and22_resp_checker_pkg.sv
// rtl/and22_resp_checker_pkg.sv - shared types, constants and helpers for the AND response checker
//
// Contents:
//   state_t     checker FSM states IDLE / RUN / DONE
//   WIDTH_DEF   default operand width
//   IDXW_DEF    default pattern index width (2*WIDTH)
//   NPAT_DEF    default number of distinct {a,b} patterns
//   CNTW_DEF    default error counter width
//   sat_inc()   saturating increment for a counter of a given width
package and22_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 2;
  localparam int IDXW_DEF  = 2 * WIDTH_DEF;
  localparam int NPAT_DEF  = 1 << IDXW_DEF;
  localparam int CNTW_DEF  = 16;

  // Increments v unless it already holds the all-ones value of a w-bit
  // counter, in which case it stays put. w must be in 1..31.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_val;
    max_val = (32'd1 << w) - 32'd1;
    if (v >= max_val) begin
      return max_val;
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/and22_resp_checker_if.sv
// rtl/and22_resp_checker_if.sv - sample and status bundle between a stimulus source and the checker
//
// Signals:
//   start             one-cycle pulse, clears statistics and begins a run
//   in_valid          in_a/in_b/dut_z form a sample to check
//   in_a, in_b        operands applied to the DUT
//   dut_z             DUT result for in_a/in_b
//   busy, done, pass  run status
//   mismatch          pulse the cycle after a failing sample
//   err_count         saturating mismatch count
//   cov_count         distinct patterns seen this run
//   first_fail_valid  a mismatch has been recorded this run
//   first_fail_idx    {a,b} of the first mismatch
// Modports:
//   master  drives samples, observes status (bench / harness side)
//   slave   the checker
interface and22_resp_checker_if #(
  parameter int WIDTH = 2,
  parameter int CNTW  = 16
);
  localparam int IDXW = 2 * WIDTH;

  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] dut_z;
  logic             busy;
  logic             done;
  logic             pass;
  logic             mismatch;
  logic [CNTW-1:0]  err_count;
  logic [IDXW:0]    cov_count;
  logic             first_fail_valid;
  logic [IDXW-1:0]  first_fail_idx;

  modport master (
    output start, in_valid, in_a, in_b, dut_z,
    input  busy, done, pass, mismatch, err_count, cov_count,
           first_fail_valid, first_fail_idx
  );

  modport slave (
    input  start, in_valid, in_a, in_b, dut_z,
    output busy, done, pass, mismatch, err_count, cov_count,
           first_fail_valid, first_fail_idx
  );

endinterface

// File: rtl/and22_resp_checker_ref_model.sv
// rtl/and22_resp_checker_ref_model.sv - combinational reference model, expected = a & b
//
// Ports:
//   a, b      operands (WIDTH bits)
//   expected  golden result (WIDTH bits)
// Swapping this module retargets the checker to another two-operand gate.
module and22_ref_model #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected
);

  assign expected = a & b;

endmodule

// File: rtl/and22_resp_checker.sv
// rtl/and22_resp_checker.sv - response checker for the AND datapath with coverage and pass/fail
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   and22_resp_checker_if.slave: samples in, run status out
// A run starts on bus.start, checks every in_valid sample in RUN against the
// reference model, and moves to DONE on the edge that covers the last of the
// NPAT distinct {a,b} patterns.
module and22_resp_checker
  import and22_chk_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  and22_resp_checker_if.slave   bus
);

  localparam int IDXW = 2 * WIDTH;
  localparam int NPAT = 1 << IDXW;

  state_t            state_q;
  state_t            state_d;

  logic [NPAT-1:0]   bitmap_q;
  logic [CNTW-1:0]   err_count_q;
  logic [IDXW:0]     cov_count_q;
  logic              mismatch_q;
  logic              ff_valid_q;
  logic [IDXW-1:0]   ff_idx_q;

  logic [WIDTH-1:0]  expected;
  logic [IDXW-1:0]   idx;
  logic              sample_en;
  logic              fail;
  logic              new_pat;
  logic              last_pat;

  and22_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a        (bus.in_a),
    .b        (bus.in_b),
    .expected (expected)
  );

  assign idx       = {bus.in_a, bus.in_b};
  // A sample coinciding with start belongs to the old run and is dropped.
  assign sample_en = (state_q == RUN) && bus.in_valid && !bus.start;
  assign fail      = (bus.dut_z != expected);
  assign new_pat   = !bitmap_q[idx];
  assign last_pat  = new_pat && (cov_count_q == (IDXW+1)'(NPAT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = RUN;
    end else if (sample_en && last_pat) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      // start clears the same statistics reset does; the FSM handles state.
      bitmap_q    <= '0;
      err_count_q <= '0;
      cov_count_q <= '0;
      mismatch_q  <= 1'b0;
      ff_valid_q  <= 1'b0;
      ff_idx_q    <= '0;
    end else if (sample_en) begin
      mismatch_q <= fail;
      if (fail) begin
        err_count_q <= CNTW'(sat_inc(32'(err_count_q), CNTW));
        if (!ff_valid_q) begin
          ff_valid_q <= 1'b1;
          ff_idx_q   <= idx;
        end
      end
      if (new_pat) begin
        bitmap_q[idx] <= 1'b1;
        cov_count_q   <= cov_count_q + 1'b1;
      end
    end else begin
      mismatch_q <= 1'b0;
    end
  end

  assign bus.busy             = (state_q == RUN);
  assign bus.done             = (state_q == DONE);
  assign bus.pass             = (state_q == DONE) && (err_count_q == '0);
  assign bus.mismatch         = mismatch_q;
  assign bus.err_count        = err_count_q;
  assign bus.cov_count        = cov_count_q;
  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_idx   = ff_idx_q;

endmodule

// File: tb/tb_and22_resp_checker.sv
// tb/tb_and22_resp_checker.sv - directed self-checking bench for and22_resp_checker
module tb_and22_resp_checker;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  and22_resp_checker_if #(.WIDTH(2), .CNTW(16)) bus ();

  and22_resp_checker #(.WIDTH(2), .CNTW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; on return the rising edge
  // has consumed them and we are at the next falling edge.
  task automatic cyc(input logic st, input logic v, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] z);
    bus.start    = st;
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.dut_z    = z;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [1:0] zval(input int i, input logic [15:0] bad);
    logic [3:0] iv;
    logic [1:0] e;
    iv = 4'(i);
    e  = iv[3:2] & iv[1:0];
    if (bad[i]) begin
      return (e == 2'b11) ? 2'b00 : 2'b11;
    end
    return e;
  endfunction

  // Present pattern i (idx = {a,b}) with correct z unless bad[i] is set.
  task automatic send(input int i, input logic [15:0] bad);
    logic [3:0] iv;
    iv = 4'(i);
    cyc(1'b0, 1'b1, iv[3:2], iv[1:0], zval(i, bad));
  endtask

  task automatic do_start();
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic sweep(input logic [15:0] bad, input int pre_cov);
    for (int i = 0; i < 16; i++) begin
      send(i, bad);
      check($sformatf("sweep_mm_%0d", i), 32'(bus.mismatch), 32'(bad[i]));
      check($sformatf("sweep_cov_%0d", i), 32'(bus.cov_count), 32'(pre_cov + i + 1));
      check($sformatf("sweep_done_%0d", i), 32'(bus.done), (i == 15) ? 32'd1 : 32'd0);
      check($sformatf("sweep_busy_%0d", i), 32'(bus.busy), (i == 15) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_pass"}, 32'(bus.pass), 32'd0);
    check({tag, "_mm"},   32'(bus.mismatch), 32'd0);
    check({tag, "_err"},  32'(bus.err_count), 32'd0);
    check({tag, "_cov"},  32'(bus.cov_count), 32'd0);
    check({tag, "_ffv"},  32'(bus.first_fail_valid), 32'd0);
    check({tag, "_ffi"},  32'(bus.first_fail_idx), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.dut_z    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Samples in IDLE are ignored.
    send(6, 16'h0040);
    check("idle_cov", 32'(bus.cov_count), 32'd0);
    check("idle_mm", 32'(bus.mismatch), 32'd0);

    // Clean sweep; sample alongside start is dropped.
    cyc(1'b1, 1'b1, 2'b01, 2'b01, 2'b11);
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_cov", 32'(bus.cov_count), 32'd0);
    check("start_err", 32'(bus.err_count), 32'd0);
    sweep(16'h0000, 0);
    check("clean_pass", 32'(bus.pass), 32'd1);
    check("clean_err", 32'(bus.err_count), 32'd0);
    check("clean_ffv", 32'(bus.first_fail_valid), 32'd0);
    // In DONE, a bad sample changes nothing.
    send(5, 16'h0020);
    check("done_ign_mm", 32'(bus.mismatch), 32'd0);
    check("done_ign_err", 32'(bus.err_count), 32'd0);
    check("done_ign_pass", 32'(bus.pass), 32'd1);

    // Single error at idx 5.
    do_start();
    check("s2_done", 32'(bus.done), 32'd0);
    sweep(16'h0020, 0);
    check("e5_err", 32'(bus.err_count), 32'd1);
    check("e5_ffi", 32'(bus.first_fail_idx), 32'd5);
    check("e5_ffv", 32'(bus.first_fail_valid), 32'd1);
    check("e5_pass", 32'(bus.pass), 32'd0);
    cyc(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    check("e5_mm_pulse_end", 32'(bus.mismatch), 32'd0);

    // Repeats of idx 3 do not advance coverage.
    do_start();
    for (int r = 0; r < 4; r++) begin
      send(3, 16'h0000);
      check($sformatf("rep_cov_%0d", r), 32'(bus.cov_count), 32'd1);
    end
    for (int i = 0; i < 16; i++) begin
      if (i != 3) begin
        send(i, 16'h0000);
        check($sformatf("rest_done_%0d", i), 32'(bus.done), (i == 15) ? 32'd1 : 32'd0);
      end
    end
    check("rep_cov_final", 32'(bus.cov_count), 32'd16);
    check("rep_pass", 32'(bus.pass), 32'd1);

    // Errors at idx 2 and 9: first_fail keeps 2.
    do_start();
    sweep(16'h0204, 0);
    check("e29_err", 32'(bus.err_count), 32'd2);
    check("e29_ffi", 32'(bus.first_fail_idx), 32'd2);
    check("e29_pass", 32'(bus.pass), 32'd0);

    // Restart mid-run after 8 patterns (with an error in them).
    do_start();
    for (int i = 0; i < 8; i++) send(i, 16'h0002);
    check("mid_cov8", 32'(bus.cov_count), 32'd8);
    check("mid_err1", 32'(bus.err_count), 32'd1);
    cyc(1'b1, 1'b1, 2'b11, 2'b11, 2'b00);
    check("restart_cov", 32'(bus.cov_count), 32'd0);
    check("restart_err", 32'(bus.err_count), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);
    check("restart_ffv", 32'(bus.first_fail_valid), 32'd0);
    sweep(16'h0000, 0);
    check("restart_pass", 32'(bus.pass), 32'd1);

    // Reset mid-run at cov_count=10, start alongside rst is ignored.
    do_start();
    for (int i = 0; i < 10; i++) send(i, 16'h0001);
    check("pre_rst_cov", 32'(bus.cov_count), 32'd10);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 2'b11, 2'b11, 2'b00);
    rst = 1'b0;
    check_reset_state("midrst");
    for (int i = 10; i < 16; i++) send(i, 16'hFFFF);
    check_reset_state("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
